wb_bram_initiator: RTL and testbench
====================================

Name: wb_bram_initiator

Overview:
Wishbone classic single-transfer initiator that drives the dual-port BRAM slave (or any WB classic slave) from a simple valid/ready command stream.
- Each accepted command becomes exactly one WB read or write cycle.
- Each WB cycle ends with one response beat carrying read data and an error flag.
- Used by test sequencers and by fabric logic that needs register-style access to the BRAM.

Parameters:
AW, 8, address width of the WB bus and cmd_addr.
DW, 8, data width; must be a multiple of 8.
TIMEOUT, 16, number of BUS-state cycles without ack/err before forced termination with error; 0 disables the timeout.

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  initiator can accept a command.
cmd_we  in  1  1 = write, 0 = read.
cmd_addr  in  AW  word address.
cmd_wdata  in  DW  write data.
cmd_sel  in  DW/8  byte selects.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DW  read data; 0 for writes and on error.
rsp_err  out  1  slave err or timeout.
wb_cyc_o  out  1  WB cycle.
wb_stb_o  out  1  WB strobe.
wb_we_o  out  1  WB write enable.
wb_adr_o  out  AW  WB address.
wb_dat_o  out  DW  WB write data.
wb_sel_o  out  DW/8  WB byte selects.
wb_ack_i  in  1  WB acknowledge.
wb_err_i  in  1  WB error.
wb_dat_i  in  DW  WB read data.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - All outputs are 0, including wb_cyc_o and wb_stb_o, immediately on reset assertion.
  - cmd_ready rises in the first clock edge after reset release.
  - The timeout counter is cleared.
- States are IDLE, BUS and RESP. The state register and all outputs are registered, except cmd_ready, which is decoded from state.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, the command fields are latched into wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o.
  - On the next edge, wb_cyc_o and wb_stb_o go to 1, the state goes to BUS, and the counter clears.
- BUS:
  - cmd_ready = 0.
  - cyc, stb, we, adr, dat and sel are held stable.
  - On a cycle where wb_ack_i or wb_err_i is sampled high, the next edge performs all of the following:
    - cyc and stb drop to 0.
    - rsp_valid goes to 1.
    - rsp_err = wb_err_i.
    - rsp_rdata = wb_dat_i if the transfer is a read without error, else 0.
    - State goes to RESP.
  - If ack and err are high simultaneously, err wins: rsp_err = 1 and rdata = 0.
  - Otherwise the counter increments each cycle. When TIMEOUT != 0 and the counter equals TIMEOUT-1 with no ack/err, the transfer terminates with rsp_err = 1 and rdata = 0.
  - The counter width is clog2(TIMEOUT+1) and the counter never wraps.
- RESP:
  - cmd_ready = 0.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready is sampled high.
  - On that edge rsp_valid goes to 0 and the state goes to IDLE. rsp_ready may already be high when rsp_valid rises.
- Latency:
  - Command accepted at edge N gives stb high during cycle N+1.
  - With a zero-wait slave (ack in the first BUS cycle), rsp_valid is high during cycle N+2.
  - The next command can be accepted one cycle after the response handshake, for a minimum of 3 cycles per transfer.
- Stray ack or err while in IDLE or RESP is ignored and causes no output change.
- cmd_* inputs are ignored when cmd_ready = 0.
- No pipelining: at most one outstanding transfer.

Test Plan:
- Write then read: write addr 0x12, data 0xA5, sel 1, with a slave that acks after 2 wait states → wb_we_o=1, adr=0x12, dat=0xA5 held for 3 cycles. Then read 0x12 returning 0xA5 → rsp_rdata=0xA5, rsp_err=0.
- Zero-wait ack: read addr 0x00 with ack in the first BUS cycle → stb high exactly 1 cycle and rsp_valid 2 cycles after cmd accept. Back-to-back commands with rsp_ready tied to 1 → one transfer per 3 cycles.
- Slave error: read addr 0x40 with wb_err_i=1 and wb_ack_i=1 in the same cycle → rsp_err=1, rsp_rdata=0x00, cyc drops next edge.
- Timeout: TIMEOUT=16, slave never acks → stb high exactly 16 cycles, then rsp_err=1, rsp_rdata=0; a later ack pulse while in IDLE is ignored.
- Response backpressure: rsp_ready held 0 for 5 cycles after a read of 0x3C → rsp_valid and data held stable, cmd_ready=0 throughout, IDLE reached one edge after rsp_ready=1.
- Reset mid-operation: assert reset_n=0 while in BUS → wb_cyc_o and wb_stb_o go to 0 without waiting for a clock edge. After release, the initiator is in IDLE with rsp_valid=0 and accepts a new command.

Source files
------------

// File: rtl/wb_bram_initiator.sv
// Wishbone classic single-transfer initiator.
// Turns each accepted valid/ready command into exactly one WB read or write
// cycle and returns one response beat carrying read data and an error flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a command; cmd_ready high once out of reset
//   BUS    | cyc/stb asserted, waiting for ack/err or timeout
//   RESP   | response beat presented, waiting for rsp_ready
module wb_bram_initiator #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [DW-1:0]     cmd_wdata,
    input  logic [DW/8-1:0]   cmd_sel,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam int SW = DW / 8;
    // A zero-width counter is not legal, so a disabled timeout keeps one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            init_q, init_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            accept;
    logic            timeout_hit;

    // init_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready   = init_q && (state_q == S_IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State register and all registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            init_q      <= 1'b0;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUS;
            S_BUS:  if (wb_err_i || wb_ack_i || timeout_hit) state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the BUS-cycle counter.
    always_comb begin
        init_d      = 1'b1;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d  = cmd_we;
                    adr_d = cmd_addr;
                    dat_d = cmd_wdata;
                    sel_d = cmd_sel;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    cnt_d = '0;
                end
            end
            S_BUS: begin
                if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
                    // err wins over a simultaneous ack; timeout reports as err
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (wb_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : wb_dat_i;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_bram_initiator.sv
// Bench for wb_bram_initiator: acts as the WB slave (memory with wait states,
// error and no-response modes) and as command source / response sink.
module tb_wb_bram_initiator;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [7:0]    cmd_addr = '0;
    logic [7:0]    cmd_wdata = '0;
    logic [0:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [7:0]    rsp_rdata;
    logic          rsp_err;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]    wb_adr_o, wb_dat_o;
    logic [0:0]    wb_sel_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;
    logic [7:0]    wb_dat_i = '0;

    wb_bram_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sm      [256];   // slave memory, written from the WB outputs
    logic [7:0] ref_mem [256];   // reference memory, written from commands
    time accept_t, prev_accept_t;

    // mode: 0 = ack after waits, 1 = ack+err after waits, 2 = never respond
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       sel;
        int         waits;
        int         mode;
        int         hold;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_stb;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic sel, input int waits, input int mode, input int hold,
                        output logic [7:0] rd, output logic er, output int stb_n);
        bit ok;
        int guard;
        logic [7:0] rd0;
        logic er0;
        stb_n = 0;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        prev_accept_t = accept_t;
        accept_t = $time;
        ok = 1'b1;
        guard = 0;
        while (wb_stb_o && guard < 40) begin
            // garbage command traffic while busy must be ignored
            cmd_valid = 1'($urandom); cmd_we = 1'($urandom);
            cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom); cmd_sel = 1'($urandom);
            if (!(wb_cyc_o && wb_we_o == we && wb_adr_o == addr && wb_dat_o == wdata &&
                  wb_sel_o == sel && !cmd_ready && !rsp_valid)) ok = 1'b0;
            if (mode != 2 && stb_n == waits) begin
                wb_ack_i = 1'b1;
                wb_err_i = (mode == 1);
                wb_dat_i = (mode == 0 && !wb_we_o) ? sm[wb_adr_o] : 8'($urandom);
                if (mode == 0 && wb_we_o && wb_sel_o[0]) sm[wb_adr_o] = wb_dat_o;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = 8'($urandom);
            end
            stb_n++;
            @(posedge clk); #1;
            guard++;
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("bus_fields_held", 32'(ok), 32'd1);
        check("rsp_valid_after_stb", {30'd0, rsp_valid, wb_cyc_o}, 32'b10);
        rd0 = rsp_rdata; er0 = rsp_err;
        rd = rd0; er = er0;
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = ~rd0;
            end else begin
                wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end
            @(posedge clk); #1;
            if (!(rsp_valid && rsp_rdata == rd0 && rsp_err == er0 && !cmd_ready &&
                  !wb_cyc_o && !wb_stb_o)) ok = 1'b0;
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        if (hold > 0) check("rsp_backpressure_hold", 32'(ok), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_done_idle", {30'd0, rsp_valid, cmd_ready}, 32'b01);
        if (we && mode == 0 && sel) ref_mem[addr] = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, exp_rd;
        logic er, exp_er;
        int stb_n, exp_stb;
        logic we, sel;
        logic [7:0] addr, wdata;
        int waits, mode, hold, r;

        for (int i = 0; i < 256; i++) begin
            sm[i] = 8'(i) ^ 8'hC3;
            ref_mem[i] = 8'(i) ^ 8'hC3;
        end
        accept_t = 0;
        prev_accept_t = 0;

        vecs[0]  = '{1'b1, 8'h12, 8'hA5, 1'b1, 2, 0, 0, 8'h00, 1'b0, 3};
        vecs[1]  = '{1'b0, 8'h12, 8'h00, 1'b1, 1, 0, 0, 8'hA5, 1'b0, 2};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 0, 0, 0, 8'hC3, 1'b0, 1};
        vecs[3]  = '{1'b0, 8'h40, 8'h00, 1'b1, 0, 1, 0, 8'h00, 1'b1, 1};
        vecs[4]  = '{1'b0, 8'h3C, 8'h00, 1'b1, 0, 0, 5, 8'hFF, 1'b0, 1};
        vecs[5]  = '{1'b1, 8'h30, 8'h77, 1'b0, 1, 0, 0, 8'h00, 1'b0, 2};
        vecs[6]  = '{1'b0, 8'h30, 8'h00, 1'b1, 0, 0, 1, 8'hF3, 1'b0, 1};
        vecs[7]  = '{1'b1, 8'h50, 8'h11, 1'b1, 2, 1, 0, 8'h00, 1'b1, 3};
        vecs[8]  = '{1'b0, 8'h50, 8'h00, 1'b1, 3, 0, 2, 8'h93, 1'b0, 4};
        vecs[9]  = '{1'b1, 8'h21, 8'h5E, 1'b1, 0, 0, 0, 8'h00, 1'b0, 1};
        vecs[10] = '{1'b0, 8'h21, 8'h00, 1'b1, 0, 0, 0, 8'h5E, 1'b0, 1};

        // reset: all outputs low while reset_n is asserted
        #1;
        check("reset_outputs_zero",
              {1'b0, cmd_ready, rsp_valid, rsp_err, rsp_rdata, wb_cyc_o, wb_stb_o,
               wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}, 32'd0);
        #21 reset_n = 1'b1;       // released between edges
        #1;
        check("cmd_ready_before_first_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("cmd_ready_after_first_edge", 32'(cmd_ready), 32'd1);

        // directed table
        for (int i = 0; i < 11; i++) begin
            xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel,
                 vecs[i].waits, vecs[i].mode, vecs[i].hold, rd, er, stb_n);
            check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("tbl%0d_stb_cycles", i), 32'(stb_n), 32'(vecs[i].exp_stb));
        end

        // back-to-back zero-wait reads with rsp_ready high: one per 3 cycles
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 8'(8'h60 + i), 8'h00, 1'b1, 0, 0, 0, rd, er, stb_n);
            check("b2b_rdata", 32'(rd), 32'(8'(8'h60 + i) ^ 8'hC3));
            if (i > 0) check("b2b_period", 32'(accept_t - prev_accept_t), 32'd30);
        end

        // timeout: slave silent, stb for exactly TIMEOUT cycles
        xfer(1'b0, 8'h21, 8'h00, 1'b1, 0, 2, 0, rd, er, stb_n);
        check("timeout_stb_cycles", 32'(stb_n), 32'd16);
        check("timeout_err_rdata", {23'd0, er, rd}, {23'd0, 1'b1, 8'h00});

        // stray ack/err while idle
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 8'h99;
        @(posedge clk); #1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("stray_ack_idle", {28'd0, rsp_valid, wb_cyc_o, wb_stb_o, cmd_ready}, 32'b0001);

        // reset in the middle of a BUS cycle
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h44; cmd_sel = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'b11);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_cyc_stb", {29'd0, wb_cyc_o, wb_stb_o, cmd_ready}, 32'b000);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", {30'd0, rsp_valid, cmd_ready}, 32'b01);
        xfer(1'b0, 8'h44, 8'h00, 1'b1, 1, 0, 0, rd, er, stb_n);
        check("post_reset_read", {23'd0, er, rd}, {23'd0, 1'b0, ref_mem[8'h44]});

        // randomized traffic against the reference memory
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom); addr = 8'($urandom_range(0, 31));
            wdata = 8'($urandom); sel = ($urandom_range(0, 3) != 0);
            waits = $urandom_range(0, 3); hold = $urandom_range(0, 2);
            r = $urandom_range(0, 99);
            mode = (r < 80) ? 0 : (r < 92) ? 1 : 2;
            exp_er  = (mode != 0);
            exp_rd  = (!we && mode == 0) ? ref_mem[addr] : 8'h00;
            exp_stb = (mode == 2) ? TIMEOUT : waits + 1;
            xfer(we, addr, wdata, sel, waits, mode, hold, rd, er, stb_n);
            check("rnd_rdata", 32'(rd), 32'(exp_rd));
            check("rnd_err", 32'(er), 32'(exp_er));
            check("rnd_stb_cycles", 32'(stb_n), 32'(exp_stb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
